// File: rtl/ex_defs_pkg.sv
// Shared definitions for the execute stage: ALU op codes, control-bit indices
// and the mul/div FSM state encoding.
// Optional build macro: RV_DIV_EN adds the iterative divider.
package ex_defs_pkg;

  localparam int unsigned CTL_W = 7;

  // Bit positions inside the 7-bit control bundle
  localparam int unsigned CTL_MEMTOREG = 6;
  localparam int unsigned CTL_REGWRITE = 5;
  localparam int unsigned CTL_MEMREAD  = 4;
  localparam int unsigned CTL_MEMWRITE = 3;
  localparam int unsigned CTL_BRANCH   = 2;
  localparam int unsigned CTL_JAL      = 1;
  localparam int unsigned CTL_JALR     = 0;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLL    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_SLT    = 5'd8;
  localparam logic [4:0] OP_SLTU   = 5'd9;
  localparam logic [4:0] OP_PASSB  = 5'd10;
  localparam logic [4:0] OP_EQ     = 5'd11;
  localparam logic [4:0] OP_NE     = 5'd12;
  localparam logic [4:0] OP_LT     = 5'd13;
  localparam logic [4:0] OP_GE     = 5'd14;
  localparam logic [4:0] OP_LTU    = 5'd15;
  localparam logic [4:0] OP_GEU    = 5'd16;
  localparam logic [4:0] OP_MUL    = 5'd17;
  localparam logic [4:0] OP_MULH   = 5'd18;
  localparam logic [4:0] OP_MULHSU = 5'd19;
  localparam logic [4:0] OP_MULHU  = 5'd20;
  localparam logic [4:0] OP_DIV    = 5'd21;
  localparam logic [4:0] OP_DIVU   = 5'd22;
  localparam logic [4:0] OP_REM    = 5'd23;
  localparam logic [4:0] OP_REMU   = 5'd24;

  typedef enum logic [1:0] {
    MdIdle = 2'd0,
    MdBusy = 2'd1,
    MdDone = 2'd2
  } md_state_e;

  function automatic logic is_mul_op(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Execute-stage port bundle: ID/EX inputs, EX/MEM outputs and the stall line.
interface execute_stage_if;
  import ex_defs_pkg::*;

  logic             valid_in;
  logic             flush_in;
  logic [4:0]       alu_op_in;
  logic             alu_src_in;
  logic [31:0]      rs1_in;
  logic [31:0]      rs2_in;
  logic [31:0]      imm_in;
  logic [31:0]      pc_in;
  logic [4:0]       rd_in;
  logic [CTL_W-1:0] ctl_in;

  logic             stall_out;
  logic [CTL_W-1:0] ctl_out;
  logic [4:0]       rd_out;
  logic             zero_out;
  logic [31:0]      alu_result_out;
  logic [31:0]      pcimm_out;
  logic [31:0]      pc_out;
  logic [31:0]      wdata_out;

  modport master (
    output valid_in, flush_in, alu_op_in, alu_src_in, rs1_in, rs2_in, imm_in, pc_in, rd_in,
           ctl_in,
    input  stall_out, ctl_out, rd_out, zero_out, alu_result_out, pcimm_out, pc_out, wdata_out
  );

  modport slave (
    input  valid_in, flush_in, alu_op_in, alu_src_in, rs1_in, rs2_in, imm_in, pc_in, rd_in,
           ctl_in,
    output stall_out, ctl_out, rd_out, zero_out, alu_result_out, pcimm_out, pc_out, wdata_out
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative multiply (and, with RV_DIV_EN, restoring divide) unit.
// Works on operand magnitudes one bit per cycle; signs are applied to the result in DONE.
module muldiv_iter
  import ex_defs_pkg::*;
#(
  parameter int unsigned MD_STEPS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic [4:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  localparam int unsigned     CntW    = $clog2(MD_STEPS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(MD_STEPS - 1);

  md_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  // hi:lo is the product, or remainder:quotient for divides
  logic [31:0]     hi_q, lo_q, mcand_q;
  logic [4:0]      op_q;
  logic            neg_q;

  logic        sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] prod_fix;
`ifdef RV_DIV_EN
  logic [32:0] div_sh, div_diff;
`endif

  // Operand signs and magnitudes for the op being started
  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    unique case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        sign_a = a[31];
        sign_b = b[31];
      end
      OP_MULHSU: sign_a = a[31];
      default: ;
    endcase
    mag_a = sign_a ? -a : a;
    mag_b = sign_b ? -b : b;
  end

  // One shift-add / shift-subtract step
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : 33'd0);
`ifdef RV_DIV_EN
    div_sh   = {hi_q, lo_q[31]};
    div_diff = div_sh - {1'b0, mcand_q};
`endif
  end

  // FSM, iteration counter and shift registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MdIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
    end else if (flush) begin
      state_q <= MdIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        MdIdle: begin
          if (start) begin
            op_q    <= op;
            cnt_q   <= '0;
            hi_q    <= '0;
            state_q <= MdBusy;
            lo_q    <= mag_b;
            mcand_q <= mag_a;
            neg_q   <= sign_a ^ sign_b;
`ifdef RV_DIV_EN
            if (is_div_op(op)) begin
              lo_q    <= mag_a;
              mcand_q <= mag_b;
              neg_q   <= (op == OP_REM || op == OP_REMU) ? sign_a : (sign_a ^ sign_b);
              // Special cases bypass the iteration entirely
              if (b == '0) begin
                state_q <= MdDone;
                hi_q    <= a;
                lo_q    <= '1;
                neg_q   <= 1'b0;
              end else if (a == 32'h8000_0000 && b == '1 && (op == OP_DIV || op == OP_REM)) begin
                state_q <= MdDone;
                hi_q    <= '0;
                lo_q    <= 32'h8000_0000;
                neg_q   <= 1'b0;
              end
            end
`endif
          end
        end
        MdBusy: begin
`ifdef RV_DIV_EN
          if (is_div_op(op_q)) begin
            if (!div_diff[32]) begin
              hi_q <= div_diff[31:0];
              lo_q <= {lo_q[30:0], 1'b1};
            end else begin
              hi_q <= div_sh[31:0];
              lo_q <= {lo_q[30:0], 1'b0};
            end
          end else
`endif
          begin
            hi_q <= mul_sum[32:1];
            lo_q <= {mul_sum[0], lo_q[31:1]};
          end
          if (cnt_q == LastCnt) begin
            state_q <= MdDone;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        MdDone:  state_q <= MdIdle;
        default: state_q <= MdIdle;
      endcase
    end
  end

  // Sign fix-up and result select, meaningful while in DONE
  always_comb begin
    prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    result   = '0;
    unique case (op_q)
      OP_MUL:                       result = prod_fix[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[63:32];
`ifdef RV_DIV_EN
      OP_DIV, OP_DIVU:              result = prod_fix[31:0];
      OP_REM, OP_REMU:              result = neg_q ? -hi_q : hi_q;
`endif
      default:                      result = '0;
    endcase
  end

  assign busy = (state_q == MdBusy);
  assign done = (state_q == MdDone);

endmodule

// File: rtl/execute_stage.sv
// RV32IM execute stage with the EX/MEM pipeline register.
// Single-cycle ALU/compare/PC+imm; mul (and div when RV_DIV_EN is defined) run in muldiv_iter
// and stall upstream until the result is ready.
module execute_stage
  import ex_defs_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MD_STEPS = 32
) (
  input logic             clk,
  input logic             reset,
  execute_stage_if.slave  ex
);
  logic [XLEN-1:0] op_b, sum, alu_res, ex_result, md_result;
  logic [4:0]      shamt;
  logic            is_cmp, cmp_true, is_md, md_op_valid, md_start, md_busy, md_done;
  logic            stall, bubble, ex_zero;

`ifdef RV_DIV_EN
  assign is_md = is_mul_op(ex.alu_op_in) || is_div_op(ex.alu_op_in);
`else
  assign is_md = is_mul_op(ex.alu_op_in);
`endif

  assign md_op_valid  = ex.valid_in && !ex.flush_in && is_md;
  assign md_start     = md_op_valid && !md_busy && !md_done;
  assign stall        = !reset && md_op_valid && !md_done;
  assign bubble       = !ex.valid_in || ex.flush_in || stall;
  assign ex.stall_out = stall;

  muldiv_iter #(
    .MD_STEPS (MD_STEPS)
  ) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .flush  (ex.flush_in),
    .op     (ex.alu_op_in),
    .a      (ex.rs1_in),
    .b      (op_b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  // Single-cycle ALU and branch compare
  always_comb begin
    op_b     = ex.alu_src_in ? ex.imm_in : ex.rs2_in;
    shamt    = op_b[4:0];
    sum      = ex.rs1_in + op_b;
    is_cmp   = 1'b0;
    cmp_true = 1'b0;
    alu_res  = '0;
    unique case (ex.alu_op_in)
      OP_ADD:   alu_res = sum;
      OP_SUB:   alu_res = ex.rs1_in - op_b;
      OP_AND:   alu_res = ex.rs1_in & op_b;
      OP_OR:    alu_res = ex.rs1_in | op_b;
      OP_XOR:   alu_res = ex.rs1_in ^ op_b;
      OP_SLL:   alu_res = ex.rs1_in << shamt;
      OP_SRL:   alu_res = ex.rs1_in >> shamt;
      OP_SRA:   alu_res = $signed(ex.rs1_in) >>> shamt;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(ex.rs1_in) < $signed(op_b)};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, ex.rs1_in < op_b};
      OP_PASSB: alu_res = op_b;
      OP_EQ:    begin is_cmp = 1'b1; cmp_true = (ex.rs1_in == op_b); end
      OP_NE:    begin is_cmp = 1'b1; cmp_true = (ex.rs1_in != op_b); end
      OP_LT:    begin is_cmp = 1'b1; cmp_true = ($signed(ex.rs1_in) < $signed(op_b)); end
      OP_GE:    begin is_cmp = 1'b1; cmp_true = ($signed(ex.rs1_in) >= $signed(op_b)); end
      OP_LTU:   begin is_cmp = 1'b1; cmp_true = (ex.rs1_in < op_b); end
      OP_GEU:   begin is_cmp = 1'b1; cmp_true = (ex.rs1_in >= op_b); end
      default:  alu_res = '0;
    endcase
    // jalr target has bit 0 cleared
    if (ex.ctl_in[CTL_JALR]) alu_res = {sum[XLEN-1:1], 1'b0};
    ex_result = is_md ? md_result : alu_res;
    ex_zero   = is_cmp ? cmp_true : (ex_result == '0);
  end

  // EX/MEM register; bubbles load all zeros
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      ex.ctl_out        <= '0;
      ex.rd_out         <= '0;
      ex.zero_out       <= 1'b0;
      ex.alu_result_out <= '0;
      ex.pcimm_out      <= '0;
      ex.pc_out         <= '0;
      ex.wdata_out      <= '0;
    end else begin
      ex.ctl_out        <= ex.ctl_in;
      ex.rd_out         <= ex.rd_in;
      ex.zero_out       <= ex_zero;
      ex.alu_result_out <= ex_result;
      ex.pcimm_out      <= ex.pc_in + ex.imm_in;
      ex.pc_out         <= ex.pc_in;
      ex.wdata_out      <= ex.rs2_in;
    end
  end

endmodule
